// File: rtl/irq_pkg.sv
// Shared types and source indices for the interrupt controller.
// Imported by the encoder and the controller top.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT_ACK
    } irq_state_t;

    localparam int IRQ_VBLANK  = 0;
    localparam int IRQ_SPRITE0 = 1;
    localparam int IRQ_APU     = 2;
    localparam int IRQ_DMA     = 3;

endpackage

// File: rtl/irq_priority_enc.sv
// Lowest-index-wins priority encoder.
// Purely combinational: request vector -> valid + index.
module irq_priority_enc
    import irq_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    // Scan high to low so the lowest set index is written last.
    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-latched, maskable interrupt controller with pulsed output,
// fixed-priority arbitration and ack-timeout re-pulse.
module interrupt_controller
    import irq_pkg::*;
#(
    parameter int NUM_SOURCES  = 4,
    parameter int PULSE_CYCLES = 3,
    parameter int ACK_TIMEOUT  = 1024,
    parameter int ID_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq_src,
    input  logic [NUM_SOURCES-1:0] irq_mask,
    input  logic                   irq_ack,
    output logic                   irq_out,
    output logic [ID_W-1:0]        irq_id,
    output logic [NUM_SOURCES-1:0] irq_pending
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);

    irq_state_t             r_state;
    irq_state_t             w_state_nxt;
    logic [NUM_SOURCES-1:0] r_pending;
    logic [NUM_SOURCES-1:0] w_pending_nxt;
    logic [NUM_SOURCES-1:0] r_hist;
    logic [NUM_SOURCES-1:0] w_edge;
    logic [NUM_SOURCES-1:0] w_clr;
    logic                   r_out;
    logic                   w_out_nxt;
    logic [ID_W-1:0]        r_id;
    logic [ID_W-1:0]        w_id_nxt;
    logic [TW-1:0]          r_timer;
    logic [TW-1:0]          w_timer_nxt;
    logic [PW-1:0]          r_pcnt;
    logic [PW-1:0]          w_pcnt_nxt;
    logic                   w_valid;
    logic [ID_W-1:0]        w_win;
    logic                   w_ack_take;
    logic                   w_still_ok;

    irq_priority_enc #(
        .N  (NUM_SOURCES),
        .IW (ID_W)
    ) u_enc (
        .i_req   (r_pending & irq_mask),
        .o_valid (w_valid),
        .o_idx   (w_win)
    );

    assign w_edge     = irq_src & ~r_hist;
    assign w_ack_take = irq_ack && (r_state != IDLE);
    assign w_still_ok = r_pending[r_id] & irq_mask[r_id];

    // Clear mask for the acknowledged ID; a same-cycle edge re-sets it.
    always_comb begin
        w_clr = '0;
        if (w_ack_take) begin
            w_clr[r_id] = 1'b1;
        end
        w_pending_nxt = (r_pending & ~w_clr) | w_edge;
    end

    // Next-state and next-output logic for the pulse/ack handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_id_nxt    = r_id;
        w_timer_nxt = r_timer;
        w_pcnt_nxt  = r_pcnt;
        unique case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_nxt = PULSE;
                    w_out_nxt   = 1'b1;
                    w_id_nxt    = w_win;
                    w_pcnt_nxt  = PW'(PULSE_CYCLES);
                end
            end
            PULSE: begin
                if (irq_ack) begin
                    w_state_nxt = IDLE;
                    w_out_nxt   = 1'b0;
                end else if (r_pcnt == PW'(1)) begin
                    w_state_nxt = WAIT_ACK;
                    w_out_nxt   = 1'b0;
                    w_timer_nxt = '0;
                end else begin
                    w_pcnt_nxt = r_pcnt - PW'(1);
                end
            end
            WAIT_ACK: begin
                w_out_nxt = 1'b0;
                if (irq_ack) begin
                    w_state_nxt = IDLE;
                end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
                    if (w_still_ok) begin
                        w_state_nxt = PULSE;
                        w_out_nxt   = 1'b1;
                        w_pcnt_nxt  = PW'(PULSE_CYCLES);
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_out_nxt   = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_hist    <= '0;
            r_out     <= 1'b0;
            r_id      <= '0;
            r_timer   <= '0;
            r_pcnt    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_hist    <= irq_src;
            r_out     <= w_out_nxt;
            r_id      <= w_id_nxt;
            r_timer   <= w_timer_nxt;
            r_pcnt    <= w_pcnt_nxt;
        end
    end

    assign irq_out     = r_out;
    assign irq_id      = r_id;
    assign irq_pending = r_pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench: directed scenarios plus random traffic
// against a behavioural model of the interrupt controller.
module tb_interrupt_controller;

    localparam int NS  = 4;
    localparam int PC  = 3;
    localparam int AT  = 8;
    localparam int IW  = 2;
    localparam int PER = PC + AT;

    logic          clk = 1'b0;
    logic          reset;
    logic [NS-1:0] irq_src;
    logic [NS-1:0] irq_mask;
    logic          irq_ack;
    logic          irq_out;
    logic [IW-1:0] irq_id;
    logic [NS-1:0] irq_pending;

    interrupt_controller #(
        .NUM_SOURCES  (NS),
        .PULSE_CYCLES (PC),
        .ACK_TIMEOUT  (AT),
        .ID_W         (IW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .irq_src     (irq_src),
        .irq_mask    (irq_mask),
        .irq_ack     (irq_ack),
        .irq_out     (irq_out),
        .irq_id      (irq_id),
        .irq_pending (irq_pending)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: an outstanding ID has an age counted from its first pulse;
    // the line is high during the first PC cycles of every PER period.
    logic [NS-1:0] m_pend;
    logic [NS-1:0] m_hist;
    bit            m_busy;
    int            m_id;
    int            m_age;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [NS-1:0] v);
        for (int i = 0; i < NS; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic m_out();
        return m_busy && ((m_age % PER) < PC);
    endfunction

    task automatic model_reset();
        m_pend = '0;
        m_hist = '0;
        m_busy = 0;
        m_id   = 0;
        m_age  = 0;
    endtask

    task automatic model_step();
        logic [NS-1:0] ev;
        ev = irq_src & ~m_hist;
        if (m_busy) begin
            if (irq_ack) begin
                m_pend[m_id] = 1'b0;
                m_busy = 0;
            end else begin
                m_age++;
                if ((m_age % PER) == 0 && !(irq_mask[m_id] && m_pend[m_id]))
                    m_busy = 0;
            end
        end else if ((m_pend & irq_mask) != '0) begin
            m_busy = 1;
            m_id   = lowest(m_pend & irq_mask);
            m_age  = 0;
        end
        m_pend = m_pend | ev;
        m_hist = irq_src;
    endtask

    task automatic check_all();
        check("out", 32'(irq_out), 32'(m_out()));
        check("id", 32'(irq_id), 32'(m_id));
        check("pend", 32'(irq_pending), 32'(m_pend));
    endtask

    task automatic step(input logic [NS-1:0] s, input logic [NS-1:0] m,
                        input logic a);
        irq_src  = s;
        irq_mask = m;
        irq_ack  = a;
        @(posedge clk);
        #1;
        model_step();
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_out", 32'(irq_out), 32'(0));
        check("rst_id", 32'(irq_id), 32'(0));
        check("rst_pend", 32'(irq_pending), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [NS-1:0] s;
        logic [NS-1:0] m;
        reset    = 1'b1;
        irq_src  = '0;
        irq_mask = '0;
        irq_ack  = 1'b0;
        model_reset();
        #12;
        check("reset_out", 32'(irq_out), 32'(0));
        check("reset_id", 32'(irq_id), 32'(0));
        check("reset_pend", 32'(irq_pending), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset mid-pulse
        step(4'b0001, 4'hF, 0);
        step(4'b0001, 4'hF, 0);
        check("rmp_first", 32'(irq_out), 32'(1));
        step(4'b0000, 4'hF, 0);
        #2;
        do_reset();
        for (int i = 0; i < 6; i++) step(4'b0000, 4'hF, 0);
        check("rmp_quiet", 32'(irq_out), 32'(0));

        // Single event, held high, ack later
        step(4'b0100, 4'hF, 0);
        step(4'b0100, 4'hF, 0);
        check("single_out", 32'(irq_out), 32'(1));
        check("single_id", 32'(irq_id), 32'(2));
        for (int i = 0; i < 6; i++) step(4'b0100, 4'hF, 0);
        step(4'b0100, 4'hF, 1);
        check("single_clr", 32'(irq_pending), 32'(0));
        for (int i = 0; i < 15; i++) step(4'b0100, 4'hF, 0);
        check("single_nore", 32'(irq_out), 32'(0));
        step(4'b0000, 4'hF, 0);

        // Priority: 3 and 1 together
        step(4'b1010, 4'hF, 0);
        step(4'b1010, 4'hF, 0);
        check("prio_first", 32'(irq_id), 32'(1));
        step(4'b1010, 4'hF, 1);
        check("prio_gap", 32'(irq_out), 32'(0));
        step(4'b1010, 4'hF, 0);
        check("prio_second", 32'(irq_id), 32'(3));
        step(4'b0000, 4'hF, 1);

        // Mask holds the pulse off but keeps pending
        step(4'b0001, 4'hE, 0);
        for (int i = 0; i < 4; i++) step(4'b0001, 4'hE, 0);
        check("mask_out", 32'(irq_out), 32'(0));
        check("mask_pend", 32'(irq_pending[0]), 32'(1));
        step(4'b0001, 4'hF, 0);
        step(4'b0001, 4'hF, 0);
        check("mask_id", 32'(irq_id), 32'(0));

        // Timeout re-pulse, ack in second pulse
        for (int i = 0; i < 11; i++) step(4'b0000, 4'hF, 0);
        check("to_repulse", 32'(irq_out), 32'(1));
        step(4'b0000, 4'hF, 1);
        check("to_ackdrop", 32'(irq_out), 32'(0));
        step(4'b0000, 4'hF, 0);

        // Collision of ack and a new edge on the same source
        step(4'b0010, 4'hF, 0);
        step(4'b0010, 4'hF, 0);
        step(4'b0000, 4'hF, 0);
        step(4'b0010, 4'hF, 1);
        check("coll_pend", 32'(irq_pending[1]), 32'(1));
        step(4'b0010, 4'hF, 0);
        check("coll_resig", 32'(irq_out), 32'(1));
        step(4'b0000, 4'hF, 1);

        // Random traffic
        s = '0;
        m = 4'hF;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < NS; b++)
                if ($urandom_range(0, 7) == 0) s[b] = ~s[b];
            if ($urandom_range(0, 15) == 0) m = NS'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step(s, m, $urandom_range(0, 9) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Collects interrupt events from several on-FPGA sources (vblank, sprite-0 hit, APU frame counter, DMA-done, ...), latches them as pending and applies a mask.
- Picks one event by fixed priority and signals it to the external CPU as a fixed-length pulse on one interrupt line, with the source index on an ID bus.
- Holds each event until the CPU acknowledges it, and re-pulses if no acknowledge arrives.
- Sits between the video/audio/DMA blocks and the CPU bus interface.

Parameters:
- NUM_SOURCES, 4, number of interrupt source inputs (1..16).
- PULSE_CYCLES, 3, clock cycles irq_out stays high per pulse (>=1).
- ACK_TIMEOUT, 1024, cycles spent in WAIT_ACK before re-pulsing the same ID (>=1).
- ID_W, $clog2(NUM_SOURCES) with minimum 1, width of irq_id.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- irq_src  in  NUM_SOURCES  source request lines, synchronous to clk; rising edge = event
- irq_mask  in  NUM_SOURCES  1 = source enabled; from CPU register block
- irq_ack  in  1  single-cycle acknowledge from CPU for the current irq_id
- irq_out  out  1  interrupt line to CPU, registered
- irq_id  out  ID_W  index of the source being signalled, registered
- irq_pending  out  NUM_SOURCES  raw pending bits, unmasked, for status readback

Behaviour:
- Reset (async, active-high) clears pending, the edge-history register, the timer and the pulse counter. It also sets irq_out=0, irq_id=0 and state=IDLE. Reset asserted mid-pulse or mid-wait drops irq_out on the same assertion and discards all pending events.
- Edge detect:
  - Pending bit i sets after edge k when irq_src[i]=1 at edge k and the history bit was 0.
  - The history bit resets to 0, so a source already high when reset is released counts as one event.
  - A level held high produces one event only.
- Pending is independent of the mask. Masking never clears a pending bit; unmasking a pending bit makes it eligible.
- Priority: the lowest index among (pending & irq_mask) wins.
- FSM has states IDLE, PULSE and WAIT_ACK.
  - IDLE: if (pending & mask) != 0, latch the winner into irq_id, set irq_out=1, load the pulse counter with PULSE_CYCLES, and go to PULSE. irq_ack in IDLE is ignored.
  - PULSE: irq_out=1 for exactly PULSE_CYCLES cycles, then irq_out=0, timer cleared, go to WAIT_ACK.
  - WAIT_ACK: irq_out=0 and the timer increments each cycle. When the timer reaches ACK_TIMEOUT-1 with no ack, re-enter PULSE with the same irq_id.
- irq_id is stable from pulse start until the ack is taken; it is not re-arbitrated while an ID is outstanding.
- Acknowledge:
  - irq_ack in PULSE or WAIT_ACK clears pending[irq_id] and goes to IDLE next cycle.
  - Ack during PULSE ends the pulse immediately (irq_out=0 next cycle).
- Simultaneous events:
  - If a new edge on the acknowledged source arrives in the same cycle as the ack, the set wins and the bit stays pending.
  - An outstanding ID whose mask bit drops is still held until ack or re-pulse. On re-pulse it is re-checked: if no longer eligible, return to IDLE instead.
- Latency: source edge sampled at edge k gives irq_out=1 after edge k+1 and irq_out=0 after edge k+1+PULSE_CYCLES. Minimum gap between two different IDs is 1 IDLE cycle.
- Timer width is $clog2(ACK_TIMEOUT+1). Pulse counter width is $clog2(PULSE_CYCLES+1). No counter wraps.

Decomposition:
- Shared package irq_pkg holds:
  - the enum irq_state_t {IDLE, PULSE, WAIT_ACK};
  - named source-index localparams (IRQ_VBLANK=0, IRQ_SPRITE0=1, IRQ_APU=2, IRQ_DMA=3).
- One natural sub-module: irq_priority_enc (combinational lowest-index encoder, NUM_SOURCES -> valid + ID_W index).

Test Plan:
- Reset mid-pulse: raise irq_src=4'b0001, assert reset at the second irq_out cycle -> irq_out=0 immediately; irq_pending=0; irq_id=0; no further pulse after release while src is low.
- Single event: mask=4'hF, irq_src[2] rises at edge 10 and stays high -> irq_out high after edges 11-13, low after 14; irq_id=2; ack at 20 clears pending; no second pulse despite src held high.
- Priority: irq_src[3] and [1] rise together -> irq_id=1 first; after ack, IDLE for one cycle, then irq_id=3 pulse.
- Mask: irq_src[0] event with mask[0]=0 -> irq_out stays 0 and irq_pending[0]=1; set mask[0]=1 -> pulse with irq_id=0 two cycles later.
- Timeout: ACK_TIMEOUT=8, no ack -> irq_out re-pulses 3 cycles every 11 cycles with the same irq_id; ack during the second pulse -> irq_out low the next cycle.
- Collision: a new edge on irq_src[1] in the same cycle as the ack for ID 1 -> irq_pending[1] remains 1 and ID 1 is re-signalled.
